// File: rtl/loop_stride_addr_gen.sv
// Multi-level loop address generator.
// Walks a nest of up to 2**LOOP_ID_W loops odometer-style. Each cycle it emits
// base + sum(idx_k * stride_k). The address is kept in an accumulator that is
// updated incrementally, so no multipliers are needed. Each loop keeps its own
// running offset (idx_k * stride_k). When a loop wraps, its offset is the span
// that has to be taken back out of the accumulator.
module loop_stride_addr_gen #(
    parameter int ADDR_WIDTH    = 8,
    parameter int ADDR_STRIDE_W = ADDR_WIDTH,
    parameter int LOOP_ID_W     = 5,
    parameter int LOOP_ITER_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stall,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     cfg_loop_iter_v,
    input  logic [LOOP_ITER_W-1:0]   cfg_loop_iter,
    input  logic [LOOP_ID_W-1:0]     cfg_loop_iter_loop_id,
    input  logic                     cfg_addr_stride_v,
    input  logic [ADDR_STRIDE_W-1:0] cfg_addr_stride,
    output logic [ADDR_WIDTH-1:0]    addr_out,
    output logic                     addr_out_valid,
    output logic [LOOP_ID_W-1:0]     loop_index,
    output logic                     loop_index_valid,
    output logic                     loop_last_iter,
    output logic                     done
);

    localparam int NUM_LOOPS = 1 << LOOP_ID_W;
    localparam logic [LOOP_ID_W:0]   NL_ONE   = (LOOP_ID_W+1)'(1);
    localparam logic [LOOP_ID_W-1:0] PTR_ONE  = LOOP_ID_W'(1);
    localparam logic [LOOP_ITER_W-1:0] IDX_ONE = LOOP_ITER_W'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic [LOOP_ID_W:0]       num_loops_q;
    logic [LOOP_ID_W-1:0]     stride_ptr_q;
    logic [LOOP_ITER_W-1:0]   iter_q   [NUM_LOOPS];
    logic [ADDR_STRIDE_W-1:0] stride_q [NUM_LOOPS];
    logic [LOOP_ITER_W-1:0]   idx_q    [NUM_LOOPS];
    logic [ADDR_WIDTH-1:0]    offset_q [NUM_LOOPS];
    logic [ADDR_WIDTH-1:0]    acc_q;
    logic [ADDR_WIDTH-1:0]    addr_hold_q;
    logic                     done_q;

    logic                  advance;
    logic                  cfg_en;
    logic                  go;
    logic                  finish;
    logic                  carry;
    logic                  all_max;
    logic [NUM_LOOPS-1:0]  change;
    logic [NUM_LOOPS-1:0]  wrap;
    logic [LOOP_ID_W-1:0]  lead_id;
    logic [ADDR_WIDTH-1:0] inc_stride;
    logic [ADDR_WIDTH-1:0] sub_sum;
    logic [ADDR_WIDTH-1:0] acc_next;

    // Strides are unsigned and are zero-extended or truncated to the address width.
    function automatic logic [ADDR_WIDTH-1:0] widen(input logic [ADDR_STRIDE_W-1:0] s);
        return ADDR_WIDTH'(s);
    endfunction

    // Nothing moves while stalled. This includes config writes and starts.
    assign advance = (state_q == RUN) && !stall;
    assign cfg_en  = (state_q == IDLE) && !stall;
    assign go      = cfg_en && start && (num_loops_q != '0);
    assign finish  = (advance && all_max) || (cfg_en && start && (num_loops_q == '0));

    // Carry chain from the innermost loop outward. It finds which loops step
    // or wrap, the outermost loop that moves, and the next accumulator value.
    always_comb begin
        carry      = 1'b1;
        change     = '0;
        wrap       = '0;
        lead_id    = '0;
        inc_stride = '0;
        sub_sum    = '0;
        for (int k = NUM_LOOPS - 1; k >= 0; k--) begin
            if (k < int'(num_loops_q)) begin
                change[k] = carry;
                if (carry) begin
                    lead_id = LOOP_ID_W'(k);
                    if (idx_q[k] == iter_q[k]) begin
                        wrap[k] = 1'b1;
                        sub_sum = sub_sum + offset_q[k];
                    end else begin
                        inc_stride = widen(stride_q[k]);
                    end
                end
                if (idx_q[k] != iter_q[k]) begin
                    carry = 1'b0;
                end
            end
        end
        all_max  = carry && (num_loops_q != '0);
        acc_next = acc_q + inc_stride - sub_sum;
    end

    // Next-state logic for the IDLE/RUN controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = RUN;
            RUN:     if (advance && all_max) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration storage. The completion pulse clears the loop count and the
    // stride pointer, but the stored values themselves are kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_loops_q  <= '0;
            stride_ptr_q <= '0;
            for (int k = 0; k < NUM_LOOPS; k++) begin
                iter_q[k]   <= '0;
                stride_q[k] <= '0;
            end
        end else begin
            if (cfg_en && cfg_loop_iter_v) begin
                iter_q[cfg_loop_iter_loop_id] <= cfg_loop_iter;
                if ({1'b0, cfg_loop_iter_loop_id} >= num_loops_q) begin
                    num_loops_q <= {1'b0, cfg_loop_iter_loop_id} + NL_ONE;
                end
            end
            if (cfg_en && cfg_addr_stride_v) begin
                stride_q[stride_ptr_q] <= cfg_addr_stride;
                stride_ptr_q           <= stride_ptr_q + PTR_ONE;
            end
            if (finish) begin
                num_loops_q  <= '0;
                stride_ptr_q <= '0;
            end
        end
    end

    // Walk datapath: the counters, the per-loop offsets, the accumulator, and the
    // last emitted address, which is held while stalled or idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            addr_hold_q <= '0;
            done_q      <= 1'b0;
            for (int k = 0; k < NUM_LOOPS; k++) begin
                idx_q[k]    <= '0;
                offset_q[k] <= '0;
            end
        end else begin
            done_q <= finish;
            if (cfg_en && start) begin
                acc_q <= base_addr;
                for (int k = 0; k < NUM_LOOPS; k++) begin
                    idx_q[k]    <= '0;
                    offset_q[k] <= '0;
                end
            end else if (advance) begin
                acc_q       <= acc_next;
                addr_hold_q <= acc_q;
                for (int k = 0; k < NUM_LOOPS; k++) begin
                    if (wrap[k]) begin
                        idx_q[k]    <= '0;
                        offset_q[k] <= '0;
                    end else if (change[k]) begin
                        idx_q[k]    <= idx_q[k] + IDX_ONE;
                        offset_q[k] <= offset_q[k] + widen(stride_q[k]);
                    end
                end
            end
        end
    end

    assign addr_out_valid   = advance;
    assign addr_out         = advance ? acc_q : addr_hold_q;
    assign loop_index_valid = advance;
    assign loop_index       = advance ? lead_id : '0;
    assign loop_last_iter   = advance && all_max;
    assign done             = done_q;

endmodule

// File: tb/tb_loop_stride_addr_gen.sv
// Directed bench for loop_stride_addr_gen with hand-computed address sequences.
// Inputs change on the falling edge. Outputs are checked 1 ns later.
module tb_loop_stride_addr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic [7:0]  base_addr;
    logic        cfg_loop_iter_v;
    logic [15:0] cfg_loop_iter;
    logic [4:0]  cfg_loop_iter_loop_id;
    logic        cfg_addr_stride_v;
    logic [7:0]  cfg_addr_stride;
    logic [7:0]  addr_out;
    logic        addr_out_valid;
    logic [4:0]  loop_index;
    logic        loop_index_valid;
    logic        loop_last_iter;
    logic        done;

    int numChecks = 0;
    int numFails  = 0;
    int expAddr[$];
    int expIdx[$];

    loop_stride_addr_gen dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .stall                 (stall),
        .base_addr             (base_addr),
        .cfg_loop_iter_v       (cfg_loop_iter_v),
        .cfg_loop_iter         (cfg_loop_iter),
        .cfg_loop_iter_loop_id (cfg_loop_iter_loop_id),
        .cfg_addr_stride_v     (cfg_addr_stride_v),
        .cfg_addr_stride       (cfg_addr_stride),
        .addr_out              (addr_out),
        .addr_out_valid        (addr_out_valid),
        .loop_index            (loop_index),
        .loop_index_valid      (loop_index_valid),
        .loop_last_iter        (loop_last_iter),
        .done                  (done)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // One comparison: count it and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic cfgIter(input int id, input int val);
        cfg_loop_iter_v       = 1'b1;
        cfg_loop_iter_loop_id = 5'(id);
        cfg_loop_iter         = 16'(val);
        @(negedge clk);
        cfg_loop_iter_v       = 1'b0;
    endtask

    task automatic cfgStride(input int val);
        cfg_addr_stride_v = 1'b1;
        cfg_addr_stride   = 8'(val);
        @(negedge clk);
        cfg_addr_stride_v = 1'b0;
    endtask

    // Start a walk and check every emitted address against expAddr/expIdx.
    // Once stallAt addresses have come out, stall is held for stallLen cycles.
    task automatic applyStimulus(input string name, input int base, input int stallAt, input int stallLen);
        int got = 0;
        int cyc = 0;
        int stallCnt = 0;
        base_addr = 8'(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (got < expAddr.size() && cyc < 100) begin
            if (got == stallAt && stallCnt < stallLen) begin
                stall = 1'b1;
                #1;
                checkOutput({name, " stall valid"}, 32'(addr_out_valid), 0);
                checkOutput({name, " stall idxvalid"}, 32'(loop_index_valid), 0);
                checkOutput({name, " stall hold"}, 32'(addr_out), 32'(expAddr[got-1]));
                stallCnt++;
            end else begin
                stall = 1'b0;
                #1;
                checkOutput($sformatf("%s valid%0d", name, got), 32'(addr_out_valid), 1);
                checkOutput($sformatf("%s addr%0d", name, got), 32'(addr_out), 32'(expAddr[got]));
                checkOutput($sformatf("%s idx%0d", name, got), 32'(loop_index), 32'(expIdx[got]));
                checkOutput($sformatf("%s idxvalid%0d", name, got), 32'(loop_index_valid), 1);
                checkOutput($sformatf("%s last%0d", name, got), 32'(loop_last_iter),
                            (got == expAddr.size() - 1) ? 1 : 0);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        stall = 1'b0;
        checkOutput({name, " count"}, 32'(got), 32'(expAddr.size()));
        #1;
        checkOutput({name, " done"}, 32'(done), 1);
        checkOutput({name, " done-cycle valid"}, 32'(addr_out_valid), 0);
        @(negedge clk);
        #1;
        checkOutput({name, " done pulse width"}, 32'(done), 0);
    endtask

    // Directed scenario sequence.
    initial begin
        reset = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        base_addr = '0;
        cfg_loop_iter_v = 1'b0;
        cfg_loop_iter = '0;
        cfg_loop_iter_loop_id = '0;
        cfg_addr_stride_v = 1'b0;
        cfg_addr_stride = '0;
        #3;
        checkOutput("reset addr", 32'(addr_out), 0);
        checkOutput("reset valid", 32'(addr_out_valid), 0);
        checkOutput("reset idx", 32'(loop_index), 0);
        checkOutput("reset idxvalid", 32'(loop_index_valid), 0);
        checkOutput("reset last", 32'(loop_last_iter), 0);
        checkOutput("reset done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] single loop");
        cfgIter(0, 3);
        cfgStride(4);
        expAddr = '{10, 14, 18, 22};
        expIdx  = '{0, 0, 0, 0};
        applyStimulus("single", 10, -1, 0);

        $display("[TB] two loops");
        cfgIter(0, 1);
        cfgIter(1, 2);
        cfgStride(16);
        cfgStride(1);
        expAddr = '{0, 1, 2, 16, 17, 18};
        expIdx  = '{1, 1, 0, 1, 1, 0};
        applyStimulus("nest", 0, -1, 0);

        $display("[TB] two loops with stall");
        cfgIter(0, 1);
        cfgIter(1, 2);
        cfgStride(16);
        cfgStride(1);
        applyStimulus("stall", 0, 2, 2);

        $display("[TB] address wrap");
        cfgIter(0, 2);
        cfgStride(4);
        expAddr = '{250, 254, 2};
        expIdx  = '{0, 0, 0};
        applyStimulus("wrap", 250, -1, 0);

        $display("[TB] no loops configured");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("empty valid", 32'(addr_out_valid), 0);
        checkOutput("empty done", 32'(done), 1);
        @(negedge clk);
        #1;
        checkOutput("empty done pulse width", 32'(done), 0);

        $display("[TB] reset mid-walk");
        cfgIter(0, 5);
        cfgStride(3);
        base_addr = 8'd40;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("midwalk addr", 32'(addr_out), 46);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("abort addr", 32'(addr_out), 0);
        checkOutput("abort valid", 32'(addr_out_valid), 0);
        checkOutput("abort idxvalid", 32'(loop_index_valid), 0);
        checkOutput("abort last", 32'(loop_last_iter), 0);
        checkOutput("abort done", 32'(done), 0);
        @(negedge clk);
        #1;
        checkOutput("abort no done", 32'(done), 0);
        reset = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        checkOutput("post-reset valid", 32'(addr_out_valid), 0);
        checkOutput("post-reset done", 32'(done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

    // Watchdog so that a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/loop_stride_addr_gen.md
LOOP_STRIDE_ADDR_GEN -- requirements
Module: loop_stride_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: address width.
REQ-002 SHALL have parameter ADDR_STRIDE_W, default ADDR_WIDTH: stride width.
REQ-003 SHALL have parameter LOOP_ID_W, default 5: loop-id width; up to 2**LOOP_ID_W loops.
REQ-004 SHALL have parameter LOOP_ITER_W, default 16: iteration-count width.
REQ-005 SHALL use one clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  begin a walk.
- stall  in  1  freeze.
- base_addr  in  ADDR_WIDTH  walk base, sampled with start.
- cfg_loop_iter_v  in  1  iteration-count write strobe.
- cfg_loop_iter  in  LOOP_ITER_W  iterations minus 1.
- cfg_loop_iter_loop_id  in  LOOP_ID_W  target loop; 0 = outermost.
- cfg_addr_stride_v  in  1  stride write strobe.
- cfg_addr_stride  in  ADDR_STRIDE_W  stride value.
- addr_out  out  ADDR_WIDTH  current address.
- addr_out_valid  out  1  address valid this cycle.
- loop_index  out  LOOP_ID_W  outermost loop advancing this cycle.
- loop_index_valid  out  1  qualifies loop_index.
- loop_last_iter  out  1  final address of walk.
- done  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL hold states IDLE and RUN only.
REQ-007 Config writes SHALL be accepted only in IDLE and ignored in RUN.
- cfg_loop_iter_v: stores cfg_loop_iter at cfg_loop_iter_loop_id.
- Loop count NL = highest id written since the last clear, plus 1.
REQ-008 Stride writes SHALL fill loop 0, 1, 2... via an internal pointer that increments per cfg_addr_stride_v; stride k applies to loop k.
REQ-009 IDLE and start SHALL latch base_addr and clear all index counters.
- NL>0: enter RUN next cycle.
- NL=0: pulse done next cycle and stay IDLE.
REQ-010 In RUN with stall=0, every cycle SHALL do the following:
- Assert addr_out_valid.
- Drive addr_out = (base + sum over k of idx_k*stride_k) mod 2**ADDR_WIDTH.
- Advance counters odometer-style; innermost (id NL-1) increments; a counter past its configured iteration count wraps to 0 and carries outward.
REQ-011 loop_index SHALL be the id of the outermost loop that increments or wraps this cycle, with loop_index_valid = addr_out_valid.
REQ-012 loop_last_iter SHALL be 1 on the cycle all counters are at their maxima; that cycle is the final address.
REQ-013 After the final address the block SHALL return to IDLE and pulse done for exactly one cycle, the cycle after the final address.
- The pulse clears NL and the stride pointer to 0.
- Stored iteration/stride values are retained but unused until rewritten.
REQ-014 stall=1 SHALL freeze all state.
- addr_out_valid and loop_index_valid are 0.
- addr_out holds its value.
- The walk resumes identically when stall drops.
REQ-015 start in RUN SHALL be ignored.
REQ-016 Address arithmetic SHALL wrap modulo 2**ADDR_WIDTH; strides are unsigned and zero-extended or truncated to ADDR_WIDTH.
REQ-017 Each walk SHALL produce exactly the product over k of (iter_k+1) valid addresses, independent of stall pattern.
REQ-018 The implementation SHALL use no multipliers; it SHALL update an accumulator incrementally (add stride of advancing loop, subtract wrapped inner-loop spans).

Reset
REQ-019 reset low SHALL asynchronously force the following, independent of clk:
- State IDLE; NL, stride pointer, counters, iteration and stride storage cleared to 0.
- Outputs: addr_out=0, addr_out_valid=0, loop_index=0, loop_index_valid=0, loop_last_iter=0, done=0.
REQ-020 Reset mid-walk SHALL abort the walk with no done pulse.

Verification
REQ-021 Single loop: iter0=3, stride=4, base=10 -> addresses 10,14,18,22 on consecutive cycles; loop_last_iter on 22; done next cycle.
REQ-022 Two loops: iter0=1/stride 16, iter1=2/stride 1, base=0 -> addresses 0,1,2,16,17,18; loop_index 1,1,0,1,1,0.
REQ-023 Stall high two cycles after second address -> valid low, addr_out held, remaining sequence unchanged, total count 6.
REQ-024 Wrap: ADDR_WIDTH=8, base=250, stride=4, iter=2 -> 250,254,2.
REQ-025 No loops configured, start -> no valid addresses, done pulse one cycle later.
REQ-026 Reset asserted mid-walk -> all outputs 0 immediately; a subsequent start with NL=0 yields an immediate done.
